// File: rtl/stick_frame_mux.sv
// stick_frame_mux: round-robin packetiser that serialises completed frames from
// N_CH sources onto one stream with optional header, SOP/EOP and timeout padding.

module stick_frame_mux_chan (
    input  logic clk_i,
    input  logic rst_i,
    input  logic frame_ready_i,
    input  logic clr_i,
    output logic pending_o,
    output logic overrun_o
);
    logic prev_q, prev_d;
    logic pending_q, pending_d;
    logic rise;

    assign rise      = frame_ready_i & ~prev_q;
    assign overrun_o = rise & pending_q;
    assign pending_o = pending_q;
    assign prev_d    = frame_ready_i;

    // a new edge wins over a same-cycle clear so the frame is not lost
    always_comb begin
        pending_d = pending_q;
        if (rise)
            pending_d = 1'b1;
        else if (clr_i)
            pending_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
        end
    end
endmodule

module stick_frame_mux #(
    parameter int N_CH    = 4,
    parameter int DW      = 32,
    parameter int SIZE_W  = 16,
    parameter int HDR_EN  = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        i_frame_ready,
    input  logic [N_CH*SIZE_W-1:0] i_frame_size,
    input  logic [N_CH*DW-1:0]     i_in_data,
    input  logic [N_CH-1:0]        i_in_vld,
    output logic [N_CH-1:0]        o_in_rdy,
    output logic [DW-1:0]          o_out_data,
    output logic                   o_out_vld,
    output logic                   o_out_sop,
    output logic                   o_out_eop,
    input  logic                   i_out_rdy,
    output logic [SIZE_W-1:0]      o_pkt_len,
    output logic [3:0]             o_ch,
    output logic                   o_busy,
    output logic                   o_err_timeout,
    output logic [15:0]            o_err_cnt
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int IDL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_PAD} state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [SIZE_W-1:0]   word_cnt_q, word_cnt_d;
    logic [IDL_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [SIZE_W-1:0]   pkt_len_q, pkt_len_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic                err_to_q;

    logic [SIZE_W-1:0]   size_arr [N_CH];
    logic [DW-1:0]       data_arr [N_CH];
    logic [N_CH-1:0]     pending, overrun, clr;

    logic                gnt_vld;
    logic [CH_W-1:0]     gnt_ch, idx;
    logic [SIZE_W-1:0]   gnt_size, gnt_len;
    logic                zero_grant, pad_entry;
    logic                beat_xfer, eop_now, first_beat;
    logic [31:0]         hdr_word;
    logic [16:0]         err_sum;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign size_arr[k] = i_frame_size[k*SIZE_W +: SIZE_W];
        assign data_arr[k] = i_in_data[k*DW +: DW];

        stick_frame_mux_chan u_chan (
            .clk_i         (sys_clk),
            .rst_i         (rst),
            .frame_ready_i (i_frame_ready[k]),
            .clr_i         (clr[k]),
            .pending_o     (pending[k]),
            .overrun_o     (overrun[k])
        );
    end

    // scan from farthest to nearest so the channel right after rr_ptr wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        idx     = '0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = CH_W'((int'(rr_ptr_q) + i) % N_CH);
            if (pending[idx]) begin
                gnt_vld = 1'b1;
                gnt_ch  = idx;
            end
        end
    end

    assign gnt_size = size_arr[gnt_ch];
    // SIZE_W-bit wrap gives the same low bits as the SIZE_W+2 bit product
    assign gnt_len  = (gnt_size + SIZE_W'(HDR_EN)) << 2;

    assign hdr_word   = {8'hA5, 4'h0, 4'(ch_q), 16'(size_q)};
    assign eop_now    = (word_cnt_q == size_q - SIZE_W'(1));
    assign first_beat = (word_cnt_q == '0);
    assign beat_xfer  = o_out_vld & i_out_rdy;

    always_comb begin
        o_out_data = '0;
        o_out_vld  = 1'b0;
        o_out_sop  = 1'b0;
        o_out_eop  = 1'b0;
        o_in_rdy   = '0;
        unique case (state_q)
            S_HDR: begin
                o_out_data = DW'(hdr_word);
                o_out_vld  = 1'b1;
                o_out_sop  = 1'b1;
            end
            S_DATA: begin
                o_out_data     = data_arr[ch_q];
                o_out_vld      = i_in_vld[ch_q];
                o_in_rdy[ch_q] = i_out_rdy;
                o_out_sop      = (HDR_EN == 0) && first_beat;
                o_out_eop      = eop_now;
            end
            S_PAD: begin
                o_out_vld = 1'b1;
                o_out_sop = (HDR_EN == 0) && first_beat;
                o_out_eop = eop_now;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        size_d     = size_q;
        word_cnt_d = word_cnt_q;
        idle_cnt_d = idle_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        pkt_len_d  = pkt_len_q;
        zero_grant = 1'b0;
        pad_entry  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    rr_ptr_d = gnt_ch;
                    if (gnt_size == '0) begin
                        zero_grant = 1'b1;
                    end else begin
                        ch_d       = gnt_ch;
                        size_d     = gnt_size;
                        pkt_len_d  = gnt_len;
                        word_cnt_d = '0;
                        idle_cnt_d = '0;
                        state_d    = (HDR_EN != 0) ? S_HDR : S_DATA;
                    end
                end
            end
            S_HDR: begin
                if (i_out_rdy)
                    state_d = S_DATA;
            end
            S_DATA: begin
                if (beat_xfer) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    idle_cnt_d = '0;
                    if (eop_now)
                        state_d = S_IDLE;
                end else if (idle_cnt_q == IDL_W'(TIMEOUT - 1)) begin
                    state_d    = S_PAD;
                    idle_cnt_d = '0;
                    pad_entry  = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            S_PAD: begin
                if (i_out_rdy) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (eop_now)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        clr = '0;
        if (beat_xfer && o_out_eop)
            clr[ch_q] = 1'b1;
        if (zero_grant)
            clr[gnt_ch] = 1'b1;
    end

    // simultaneous overrun and timeout add two
    assign err_sum   = {1'b0, err_cnt_q} + 17'(|overrun) + 17'(pad_entry);
    assign err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            rr_ptr_q   <= CH_W'(N_CH - 1);
            size_q     <= '0;
            word_cnt_q <= '0;
            idle_cnt_q <= '0;
            pkt_len_q  <= '0;
            err_cnt_q  <= '0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            rr_ptr_q   <= rr_ptr_d;
            size_q     <= size_d;
            word_cnt_q <= word_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            pkt_len_q  <= pkt_len_d;
            err_cnt_q  <= err_cnt_d;
            err_to_q   <= pad_entry;
        end
    end

    assign o_pkt_len     = pkt_len_q;
    assign o_ch          = 4'(ch_q);
    assign o_busy        = (state_q != S_IDLE);
    assign o_err_timeout = err_to_q;
    assign o_err_cnt     = err_cnt_q;
endmodule

// File: doc/stick_frame_mux.md
# stick_frame_mux

Multi-channel frame packetiser for the stick acquisition path: it collects completed frames from N_CH independent frame sources and serialises them onto one 32-bit stream toward packet_sender. Each source provides a frame-ready flag, a frame size in words, and a valid/ready data stream. Frames are scheduled round-robin, framed with SOP/EOP, optionally prefixed with a header word, and length-checked. A stalled source is padded out on timeout so downstream packets keep their announced length.

## Interface

- N_CH, 4, number of frame sources (1..16)
- DW, 32, data word width (fixed 32 for packet_sender)
- SIZE_W, 16, width of frame size / packet length fields
- HDR_EN, 1, 1 = prepend one header word per frame
- TIMEOUT, 4096, idle-cycle limit inside a frame before padding

- sys_clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- i_frame_ready  in  N_CH  per-channel frame-complete level; rising edge marks a pending frame
- i_frame_size  in  N_CH*SIZE_W  per-channel frame length in DW words; channel k at [k*SIZE_W +: SIZE_W]
- i_in_data  in  N_CH*DW  per-channel frame data; channel k at [k*DW +: DW]
- i_in_vld  in  N_CH  per-channel data valid
- o_in_rdy  out  N_CH  per-channel data ready
- o_out_data  out  DW  serialised output word
- o_out_vld  out  1  output valid
- o_out_sop  out  1  first beat of packet
- o_out_eop  out  1  last beat of packet
- i_out_rdy  in  1  downstream ready
- o_pkt_len  out  SIZE_W  packet length in bytes, stable from SOP to EOP
- o_ch  out  4  channel currently granted
- o_busy  out  1  a packet is in progress
- o_err_timeout  out  1  one-cycle pulse when a frame enters padding
- o_err_cnt  out  16  saturating count of timeouts plus overruns

## Operation

- Edge detect: prev_ready is registered each cycle. `pending[k]` is set on a rising edge of i_frame_ready[k] and cleared when the channel's EOP beat transfers. If set and clear occur in the same cycle, the set wins.
- Overrun: a rising edge while pending[k] is already set increments o_err_cnt; no second frame is queued.
- FSM states: IDLE, HDR, DATA, PAD.
  - IDLE: if any pending bit is set, grant the first pending channel searching from rr_ptr+1 upward, with wrap-around. Latch ch and size = i_frame_size[ch], set rr_ptr = ch, and go to HDR if HDR_EN, else DATA.
  - Zero-size frame: clear pending, emit nothing, stay in IDLE.
  - HDR: drive {8'hA5, 4'h0, ch[3:0], size[15:0]} (size truncated/zero-extended to 16) with vld and sop. On i_out_rdy, go to DATA.
  - DATA: pass-through with no register stage:
    - o_out_data = i_in_data[ch]
    - o_out_vld = i_in_vld[ch]
    - o_in_rdy[ch] = i_out_rdy; all other o_in_rdy bits = 0
    - sop asserts on the first data beat only when HDR_EN=0
    - eop asserts when word_cnt == size-1
    - word_cnt increments on vld & rdy
    - The beat with eop & vld & rdy returns the FSM to IDLE.
  - PAD: entered from DATA when idle_cnt reaches TIMEOUT. idle_cnt counts consecutive DATA cycles without a transfer and resets on every transfer.
    - Drive data 0, vld=1, and hold o_in_rdy[ch]=0.
    - Continue counting words with the same eop rule, then go to IDLE.
    - o_err_timeout pulses on entry; o_err_cnt increments.
- Length: o_pkt_len = (size + HDR_EN) << 2, computed in SIZE_W+2 bits and truncated to SIZE_W. It is latched at grant.
- o_err_cnt saturates at 16'hFFFF. If an overrun and a timeout occur in the same cycle, it adds 2, still saturating.

## Timing

- Reset values:
  - all outputs 0, including o_ch and o_pkt_len
  - pending = 0, prev_ready = 0
  - rr_ptr = N_CH-1, so channel 0 has priority first
  - FSM = IDLE
- Latency:
  - rising edge sampled at cycle t sets pending at t+1
  - grant occurs at t+1
  - the first output beat (header or data, with sop) is valid at t+2
- Handshake: a beat transfers when o_out_vld & i_out_rdy. While unaccepted, data, sop and eop hold stable; in HDR and PAD the block never drops vld.
- Turnaround: after an EOP transfer, the FSM spends exactly one IDLE cycle before the next grant. Minimum inter-packet gap is 1 cycle.
- rst asserted mid-packet: everything returns to reset values on the next edge, and the packet is abandoned without an EOP.

## Test plan

- Single channel, HDR_EN=1, ch0 size=4, i_out_rdy=1: header 0xA5000004 with sop, then 4 data words with eop on the last; o_pkt_len=20; pending0 cleared.
- Channels 1, 2 and 3 raise ready in the same cycle: packets go out in order 1, 2, 3. Then ch1 again plus ch0 together → 0 first, since rr_ptr=3 wraps.
- Random i_out_rdy (50%) and random i_in_vld for ch2 size=257: exactly 257 data beats, output data equal to the input sequence, no duplicate or lost words.
- ch0 size=8, source stops after 3 words, TIMEOUT=16: after 16 idle cycles o_err_timeout pulses, 5 zero words are emitted with eop on the last, and o_err_cnt=1.
- Second ready edge on ch1 while pending1 is set → o_err_cnt increments and only one ch1 packet is sent. Zero-size frame on ch3 → no output, pending3 cleared.
- rst asserted for 1 cycle in the middle of DATA: all outputs 0 next cycle, and the next frame-ready edge produces a fresh sop.
